// File: rtl/ibuffer_fifo.sv
// ibuffer_fifo -- instruction buffer between fetch and decode.
//
// Circular buffer of DEPTH {pc, inst} entries. Fetch pushes up to two entries
// per cycle when wr_ready is high. Decode sees the two oldest entries
// combinationally and retires 0..2 of them per cycle via rd_issue. A stall
// from the controller freezes retirement, and a flush empties the buffer.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               discard all contents (pointers/count to 0)
//   stall_id            decode holding; no retirement this edge
//   wr_valid0/1         fetch slot valids (slot 1 only counts with slot 0)
//   wr_pc0/1, wr_inst0/1  fetch slot payloads
//   wr_ready            at least two free entries (registered count only)
//   rd_valid0/1         oldest / second-oldest entry present
//   rd_pc0/1, rd_inst0/1  payload of the two oldest entries, 0 when invalid
//   rd_issue            entries decode consumes (3 behaves as 2)
//
// Optional feature, enabled by defining IBUF_FLUSH_CNT_EN:
//   flush_cnt           saturating count of edges with flush high (not in rst)

module ibuffer_fifo_rd_lane (
  input  logic        vld,
  input  logic [63:0] ent,
  output logic        rd_valid,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_inst
);
  // Invalid lanes drive zeros so decode never sees stale storage.
  assign rd_valid = vld;
  assign rd_pc    = vld ? ent[63:32] : 32'd0;
  assign rd_inst  = vld ? ent[31:0]  : 32'd0;
endmodule

module ibuffer_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_id,
  input  logic        wr_valid0,
  input  logic        wr_valid1,
  input  logic [31:0] wr_pc0,
  input  logic [31:0] wr_pc1,
  input  logic [31:0] wr_inst0,
  input  logic [31:0] wr_inst1,
  output logic        wr_ready,
  output logic        rd_valid0,
  output logic        rd_valid1,
  output logic [31:0] rd_pc0,
  output logic [31:0] rd_pc1,
  output logic [31:0] rd_inst0,
  output logic [31:0] rd_inst1,
`ifdef IBUF_FLUSH_CNT_EN
  output logic [31:0] flush_cnt,
`endif
  input  logic [1:0]  rd_issue
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_ent_t;

  ibuf_ent_t         mem [DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   free_cnt;
  logic [1:0]        push_n, pop_n, issue_sat;

  assign free_cnt = (ADDR_W+1)'(DEPTH) - count;
  assign wr_ready = !rst && (free_cnt >= (ADDR_W+1)'(2));

  // Slot 1 alone is not a legal request and is dropped.
  always_comb begin
    push_n = 2'd0;
    if (wr_ready && wr_valid0) push_n = wr_valid1 ? 2'd2 : 2'd1;
  end

  // Pop is clamped to what is actually present; rd_issue=3 behaves as 2.
  assign issue_sat = (rd_issue == 2'd3) ? 2'd2 : rd_issue;
  always_comb begin
    pop_n = 2'd0;
    if (!stall_id) begin
      if ((ADDR_W+1)'(issue_sat) > count) pop_n = count[1:0];
      else                                pop_n = issue_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ADDR_W'(pop_n);
      tail  <= tail + ADDR_W'(push_n);
      count <= count + (ADDR_W+1)'(push_n) - (ADDR_W+1)'(pop_n);
    end
  end

  // Storage is never cleared; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_n != 2'd0) mem[tail] <= '{pc: wr_pc0, inst: wr_inst0};
      if (push_n == 2'd2) mem[tail + ADDR_W'(1)] <= '{pc: wr_pc1, inst: wr_inst1};
    end
  end

  // Read lanes: lane g presents entry head+g.
  logic [NUM_LANES-1:0]       lane_vld;
  logic [NUM_LANES-1:0][63:0] lane_ent;
  logic [NUM_LANES-1:0]       lane_rd_vld;
  logic [NUM_LANES-1:0][31:0] lane_pc, lane_inst;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_ent[g] = mem[head + ADDR_W'(g)];
    assign lane_vld[g] = !rst && (count > (ADDR_W+1)'(g));
  end

  ibuffer_fifo_rd_lane u_lane [NUM_LANES-1:0] (
    .vld      (lane_vld),
    .ent      (lane_ent),
    .rd_valid (lane_rd_vld),
    .rd_pc    (lane_pc),
    .rd_inst  (lane_inst)
  );

  assign rd_valid0 = lane_rd_vld[0];
  assign rd_valid1 = lane_rd_vld[1];
  assign rd_pc0    = lane_pc[0];
  assign rd_pc1    = lane_pc[1];
  assign rd_inst0  = lane_inst[0];
  assign rd_inst1  = lane_inst[1];

`ifdef IBUF_FLUSH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           flush_cnt <= '0;
    else if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
  end
`endif

endmodule
